// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared types, op encodings and request fault check for dmem_arb_ctrl
// Rev    : 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [2:0] OP_B        = 3'b000;
    localparam logic [2:0] OP_H        = 3'b001;
    localparam logic [2:0] OP_W        = 3'b010;
    localparam logic [2:0] OP_BU       = 3'b100;
    localparam logic [2:0] OP_HU       = 3'b101;
    localparam logic [2:0] MEM_OP_WORD = 3'b010;

    // Illegal op, unsigned store, or misaligned halfword/word access.
    function automatic logic req_fault(input logic [2:0] op, input logic we,
                                       input logic [1:0] off);
        logic w_fault;
        case (op)
            OP_B:    w_fault = 1'b0;
            OP_BU:   w_fault = we;
            OP_H:    w_fault = off[0];
            OP_HU:   w_fault = we | off[0];
            OP_W:    w_fault = (off != 2'b00);
            default: w_fault = 1'b1;
        endcase
        return w_fault;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_arb_ctrl_if
// Brief  : Two requester ports plus the word-only memory port of dmem_arb_ctrl
// Rev    : 1.0
// ============================================================================
interface dmem_arb_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              p0_req_valid;
    logic              p0_req_ready;
    logic [ADDR_W-1:0] p0_req_addr;
    logic              p0_req_we;
    logic [2:0]        p0_req_op;
    logic [31:0]       p0_req_wdata;
    logic              p0_rsp_valid;
    logic              p0_rsp_ready;
    logic [31:0]       p0_rsp_rdata;
    logic              p0_rsp_err;

    logic              p1_req_valid;
    logic              p1_req_ready;
    logic [ADDR_W-1:0] p1_req_addr;
    logic              p1_req_we;
    logic [2:0]        p1_req_op;
    logic [31:0]       p1_req_wdata;
    logic              p1_rsp_valid;
    logic              p1_rsp_ready;
    logic [31:0]       p1_rsp_rdata;
    logic              p1_rsp_err;

    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_op;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;
    logic              busy;

    // Requesters and memory side.
    modport master (
        output p0_req_valid, p0_req_addr, p0_req_we, p0_req_op, p0_req_wdata, p0_rsp_ready,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
        output p1_req_valid, p1_req_addr, p1_req_we, p1_req_op, p1_req_wdata, p1_rsp_ready,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
        input  mem_addr, mem_wdata, mem_op, mem_read, mem_write, busy,
        output mem_rdata
    );

    // Arbiter/controller side.
    modport slave (
        input  p0_req_valid, p0_req_addr, p0_req_we, p0_req_op, p0_req_wdata, p0_rsp_ready,
        output p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
        input  p1_req_valid, p1_req_addr, p1_req_we, p1_req_op, p1_req_wdata, p1_rsp_ready,
        output p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
        output mem_addr, mem_wdata, mem_op, mem_read, mem_write, busy,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// Module : dmem_lane
// Brief  : Byte/half lane extract with extension, and sub-word merge into a word
// Rev    : 1.0
// ============================================================================
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_op,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);

    logic [15:0] w_lane;

    always_comb begin
        w_lane   = 16'(i_word >> {i_offset, 3'b000});
        o_rdata  = '0;
        o_merged = i_word;
        case (i_op)
            OP_B:    o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
            OP_BU:   o_rdata = {24'h0, w_lane[7:0]};
            OP_H:    o_rdata = {{16{w_lane[15]}}, w_lane};
            OP_HU:   o_rdata = {16'h0, w_lane};
            OP_W:    o_rdata = i_word;
            default: o_rdata = '0;
        endcase
        // Halfword lane is chosen by offset[1] alone; alignment was checked at accept.
        case (i_op)
            OP_B, OP_BU: o_merged[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
            OP_H, OP_HU: o_merged[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            OP_W:        o_merged = i_wdata;
            default:     o_merged = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dmem_arb_ctrl
// Brief  : Two-port round-robin arbiter onto a word-only memory, with RMW stores
// Rev    : 1.0
// ============================================================================
module dmem_arb_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 32,
    parameter int RR_EN     = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arb_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_mem_words = ADDR_W'(MEM_WORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_grant;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [2:0]        r_op;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic              w_sel;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_we;
    logic [2:0]        w_sel_op;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_err;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_rsp0;
    logic              w_rsp1;
    logic [31:0]       w_extract;
    logic [31:0]       w_merged;

    // Arbiter: with both valid, round-robin hands the grant to the port that did not win last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == IDLE) begin
            if (bus.p0_req_valid && bus.p1_req_valid) begin
                if ((RR_EN != 0) && !r_last_grant) w_gnt1 = 1'b1;
                else                               w_gnt0 = 1'b1;
            end else if (bus.p0_req_valid) begin
                w_gnt0 = 1'b1;
            end else if (bus.p1_req_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_accept    = w_gnt0 | w_gnt1;
    assign w_sel       = w_gnt1;
    assign w_sel_addr  = w_sel ? bus.p1_req_addr  : bus.p0_req_addr;
    assign w_sel_we    = w_sel ? bus.p1_req_we    : bus.p0_req_we;
    assign w_sel_op    = w_sel ? bus.p1_req_op    : bus.p0_req_op;
    assign w_sel_wdata = w_sel ? bus.p1_req_wdata : bus.p0_req_wdata;
    assign w_sel_err   = req_fault(w_sel_op, w_sel_we, w_sel_addr[1:0]) ||
                         ((w_sel_addr >> 2) >= c_mem_words);

    always_comb begin
        w_state_nxt = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_sel_err)                          w_state_nxt = RSP;
                    else if (!w_sel_we || w_sel_op != OP_W) w_state_nxt = RD;
                    else                                    w_state_nxt = WR;
                end
            end
            RD: begin
                w_mem_read  = 1'b1;
                w_state_nxt = r_we ? WR : RSP;
            end
            WR: begin
                w_mem_write = 1'b1;
                w_state_nxt = RSP;
            end
            RSP: begin
                if (r_owner ? bus.p1_rsp_ready : bus.p0_rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_op         <= 3'b000;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_grant <= w_sel;
                r_owner      <= w_sel;
                r_addr       <= w_sel_addr;
                r_we         <= w_sel_we;
                r_op         <= w_sel_op;
                r_wdata      <= w_sel_wdata;
                r_rdata      <= '0;
                r_err        <= w_sel_err;
            end else if (r_state == RD) begin
                // Memory word arrives this edge: loads keep the lane, stores keep the merge.
                if (r_we) r_wdata <= w_merged;
                else      r_rdata <= w_extract;
            end
        end
    end

    dmem_lane u_lane (
        .i_word   (bus.mem_rdata),
        .i_wdata  (r_wdata),
        .i_offset (r_addr[1:0]),
        .i_op     (r_op),
        .o_rdata  (w_extract),
        .o_merged (w_merged)
    );

    assign w_rsp0 = (r_state == RSP) && !r_owner;
    assign w_rsp1 = (r_state == RSP) &&  r_owner;

    assign bus.p0_req_ready = w_gnt0;
    assign bus.p1_req_ready = w_gnt1;
    assign bus.p0_rsp_valid = w_rsp0;
    assign bus.p1_rsp_valid = w_rsp1;
    assign bus.p0_rsp_rdata = w_rsp0 ? r_rdata : 32'h0;
    assign bus.p1_rsp_rdata = w_rsp1 ? r_rdata : 32'h0;
    assign bus.p0_rsp_err   = w_rsp0 & r_err;
    assign bus.p1_rsp_err   = w_rsp1 & r_err;

    assign bus.mem_addr  = 32'(r_addr) & 32'hFFFF_FFFC;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_op    = MEM_OP_WORD;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_arb_ctrl
// Brief  : Directed + random bench for dmem_arb_ctrl with a word-array memory model
// Rev    : 1.0
// ============================================================================
module tb_dmem_arb_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arb_ctrl_if #(.ADDR_W(32)) bus ();

    dmem_arb_ctrl #(.ADDR_W(32), .MEM_WORDS(32), .RR_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word memory: reads at negedge, writes at posedge; backdoor port for preload.
    logic [31:0] mem [32];
    logic        bd_we;
    logic [4:0]  bd_idx;
    logic [31:0] bd_data;

    always @(negedge clk) if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[6:2]];
    always @(posedge clk) begin
        if (bd_we)              mem[bd_idx] <= bd_data;
        else if (bus.mem_write) mem[bus.mem_addr[6:2]] <= bus.mem_wdata;
    end

    int          rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, badaddr_cnt = 0;
    logic [31:0] last_rd_addr = 32'h0;
    always @(negedge clk) begin
        if (bus.mem_read) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= bus.mem_addr;
        end
        if (bus.mem_write) wr_cnt <= wr_cnt + 1;
        if (bus.mem_read && bus.mem_write) overlap_cnt <= overlap_cnt + 1;
        if ((bus.mem_read || bus.mem_write) && (bus.mem_addr[1:0] != 2'b00 || bus.mem_op != 3'b010))
            badaddr_cnt <= badaddr_cnt + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed view of the memory, computed from access size and offset.
    logic [31:0] ref_mem [32];

    function automatic void model(input logic [31:0] addr, input logic we, input logic [2:0] op,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err,
                                  output int lat, output int nrd, output int nwr);
        int     size;
        bit     sgn;
        int     off;
        longint word, raw, mask, wdl;
        case (op)
            3'b000:  begin size = 1; sgn = 1; end
            3'b100:  begin size = 1; sgn = 0; end
            3'b001:  begin size = 2; sgn = 1; end
            3'b101:  begin size = 2; sgn = 0; end
            3'b010:  begin size = 4; sgn = 0; end
            default: begin size = 0; sgn = 0; end
        endcase
        err = (size == 0) || (we && (op == 3'b100 || op == 3'b101)) || (addr / 4 >= 32);
        if (size != 0 && (addr % size) != 0) err = 1'b1;
        rd = 32'h0;
        if (err) begin
            lat = 1; nrd = 0; nwr = 0;
            return;
        end
        off  = int'(addr % 4);
        word = ref_mem[addr / 4];
        mask = (64'sd1 <<< (8 * size)) - 1;
        if (!we) begin
            raw = (word >> (8 * off)) & mask;
            if (sgn && raw >= (64'sd1 <<< (8 * size - 1))) raw = raw - (64'sd1 <<< (8 * size));
            rd  = raw[31:0];
            lat = 2; nrd = 1; nwr = 0;
        end else begin
            wdl  = wd;
            mask = mask << (8 * off);
            raw  = (word & ~mask) | ((wdl << (8 * off)) & mask);
            ref_mem[addr / 4] = raw[31:0];
            lat = (size == 4) ? 2 : 3;
            nrd = (size == 4) ? 0 : 1;
            nwr = 1;
        end
    endfunction

    task automatic drive_req(input int p, input logic v, input logic [31:0] a, input logic we,
                             input logic [2:0] op, input logic [31:0] wd);
        if (p == 0) begin
            bus.p0_req_valid = v; bus.p0_req_addr = a; bus.p0_req_we = we;
            bus.p0_req_op = op;   bus.p0_req_wdata = wd;
        end else begin
            bus.p1_req_valid = v; bus.p1_req_addr = a; bus.p1_req_we = we;
            bus.p1_req_op = op;   bus.p1_req_wdata = wd;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) bus.p0_rsp_ready = v;
        else        bus.p1_rsp_ready = v;
    endtask

    function automatic logic ready_of(input int p);
        return (p == 0) ? bus.p0_req_ready : bus.p1_req_ready;
    endfunction
    function automatic logic rsp_valid_of(input int p);
        return (p == 0) ? bus.p0_rsp_valid : bus.p1_rsp_valid;
    endfunction
    function automatic logic [31:0] rsp_rdata_of(input int p);
        return (p == 0) ? bus.p0_rsp_rdata : bus.p1_rsp_rdata;
    endfunction
    function automatic logic rsp_err_of(input int p);
        return (p == 0) ? bus.p0_rsp_err : bus.p1_rsp_err;
    endfunction

    // One complete transaction on port p; entered and left at posedge+1.
    task automatic do_txn(input int p, input logic [31:0] a, input logic we, input logic [2:0] op,
                          input logic [31:0] wd, input int hold);
        logic [31:0] erd;
        logic        eerr;
        int          elat, enrd, enwr, lat, r0, w0;
        bit          got;
        model(a, we, op, wd, erd, eerr, elat, enrd, enwr);
        r0 = rd_cnt;
        w0 = wr_cnt;
        set_rsp_ready(p, 1'b0);
        drive_req(p, 1'b1, a, we, op, wd);
        #1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (ready_of(p)) got = 1'b1;
            else begin @(posedge clk); #2; end
        end
        check("accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        drive_req(p, 1'b0, a, we, op, wd);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10 && !got; k++) begin
            if (rsp_valid_of(p)) begin got = 1'b1; lat = k; end
            else begin @(posedge clk); #1; end
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(elat));
        check("other_rsp_valid", 32'(rsp_valid_of(1 - p)), 32'd0);
        check("rsp_rdata", rsp_rdata_of(p), erd);
        check("rsp_err", 32'(rsp_err_of(p)), 32'(eerr));
        repeat (hold) begin @(posedge clk); #1; end
        set_rsp_ready(p, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(p, 1'b0);
        check("busy_after_rsp", 32'(bus.busy), 32'd0);
        check("rd_strobes", 32'(rd_cnt - r0), 32'(enrd));
        check("wr_strobes", 32'(wr_cnt - w0), 32'(enwr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, erd, hold_rd;
        logic        eerr;
        int          elat, enrd, enwr, w, r0, w0, rem0, rem1, p;
        int          order [4];
        bit          got, bad;
        logic [2:0]  op;
        logic        we;
        logic [31:0] addr;

        rst   = 1'b1;
        bd_we = 1'b0; bd_idx = 5'd0; bd_data = 32'h0;
        drive_req(0, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
        drive_req(1, 1'b0, 32'h0, 1'b0, 3'b000, 32'h0);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);

        // Preload through the backdoor while held in reset.
        for (int i = 0; i < 32; i++) begin
            v = (i == 2) ? 32'h8899AABB : $urandom();
            ref_mem[i] = v;
            bd_we = 1'b1; bd_idx = 5'(i); bd_data = v;
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready0", 32'(bus.p0_req_ready), 32'd0);
        check("rst_ready1", 32'(bus.p1_req_ready), 32'd0);
        check("rst_rsp_valid0", 32'(bus.p0_rsp_valid), 32'd0);
        check("rst_rsp_valid1", 32'(bus.p1_rsp_valid), 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_rdata0", bus.p0_rsp_rdata, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Sign-extended byte load from the preloaded word.
        do_txn(0, 32'h09, 1'b0, 3'b000, 32'h0, 0);
        check("lb_read_addr", last_rd_addr, 32'h08);

        // Halfword store on port 1 goes through read-modify-write.
        do_txn(1, 32'h0A, 1'b1, 3'b001, 32'h00001234, 0);
        check("sh_mem_word2", mem[2], 32'h1234AABB);

        // Both ports contend for four transactions.
        set_rsp_ready(0, 1'b1);
        set_rsp_ready(1, 1'b1);
        drive_req(0, 1'b1, 32'h08, 1'b0, 3'b010, 32'h0);
        drive_req(1, 1'b1, 32'h09, 1'b0, 3'b100, 32'h0);
        rem0 = 2; rem1 = 2;
        for (int g = 0; g < 4; g++) begin
            #1;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                if (bus.p0_req_ready || bus.p1_req_ready) got = 1'b1;
                else begin @(posedge clk); #2; end
            end
            check("rr_grant_seen", 32'(got), 32'd1);
            check("rr_single_ready", 32'(bus.p0_req_ready & bus.p1_req_ready), 32'd0);
            w = bus.p0_req_ready ? 0 : 1;
            order[g] = w;
            if (w == 0) model(32'h08, 1'b0, 3'b010, 32'h0, erd, eerr, elat, enrd, enwr);
            else        model(32'h09, 1'b0, 3'b100, 32'h0, erd, eerr, elat, enrd, enwr);
            @(posedge clk); #1;
            if (w == 0) begin rem0--; if (rem0 == 0) bus.p0_req_valid = 1'b0; end
            else        begin rem1--; if (rem1 == 0) bus.p1_req_valid = 1'b0; end
            got = 1'b0;
            v   = 32'h0;
            for (int k = 0; k < 10 && !got; k++) begin
                if (rsp_valid_of(w)) begin got = 1'b1; v = rsp_rdata_of(w); end
                else begin @(posedge clk); #1; end
            end
            check("rr_rsp_seen", 32'(got), 32'd1);
            check("rr_rdata", v, erd);
            @(posedge clk); #1;
        end
        for (int g = 0; g < 4; g++) check("rr_order", 32'(order[g]), 32'(g % 2));
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);

        // Error responses: misaligned word, and address past the end of memory.
        do_txn(0, 32'h06, 1'b0, 3'b010, 32'h0, 0);
        do_txn(0, 32'h80, 1'b0, 3'b010, 32'h0, 0);

        // Response held off for five cycles while the other port is waiting.
        model(32'h08, 1'b0, 3'b010, 32'h0, erd, eerr, elat, enrd, enwr);
        drive_req(1, 1'b1, 32'h08, 1'b0, 3'b010, 32'h0);
        #1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.p1_req_ready) got = 1'b1;
            else begin @(posedge clk); #2; end
        end
        check("hold_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        drive_req(1, 1'b0, 32'h08, 1'b0, 3'b010, 32'h0);
        drive_req(0, 1'b1, 32'h00, 1'b0, 3'b000, 32'h0);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (bus.p1_rsp_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("hold_rsp_seen", 32'(got), 32'd1);
        hold_rd = bus.p1_rsp_rdata;
        check("hold_rdata", hold_rd, erd);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.p1_rsp_valid), 32'd1);
            check("hold_rdata_stable", bus.p1_rsp_rdata, erd);
            check("hold_ready", 32'({bus.p0_req_ready, bus.p1_req_ready}), 32'd0);
            check("hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.p0_req_valid = 1'b0;
        set_rsp_ready(1, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(1, 1'b0);
        check("hold_released", 32'(bus.busy), 32'd0);

        // Reset asserted during the write phase of a byte store; the store must not land.
        w0 = wr_cnt;
        r0 = rd_cnt;
        drive_req(0, 1'b1, 32'h11, 1'b1, 3'b000, 32'h000000AB);
        #1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (bus.p0_req_ready) got = 1'b1;
            else begin @(posedge clk); #2; end
        end
        check("sb_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 32'h11, 1'b1, 3'b000, 32'h000000AB);
        @(posedge clk); #1;
        check("sb_in_wr", 32'(bus.mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_wr_drop", 32'(bus.mem_write), 32'd0);
        check("rst_rd_drop", 32'(bus.mem_read), 32'd0);
        check("rst_busy_drop", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.p0_rsp_valid || bus.p1_rsp_valid || bus.busy) bad = 1'b1;
        end
        check("rst_no_rsp", 32'(bad), 32'd0);
        check("rst_no_write", 32'(wr_cnt - w0), 32'd0);
        check("rst_one_read", 32'(rd_cnt - r0), 32'd1);
        do_txn(0, 32'h10, 1'b0, 3'b010, 32'h0, 0);

        // Randomized mix of ports, ops, alignments and out-of-range addresses.
        for (int t = 0; t < 40; t++) begin
            p = int'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1:    op = 3'b000;
                2, 7:    op = 3'b001;
                3, 4, 9: op = 3'b010;
                5:       op = 3'b100;
                6:       op = 3'b101;
                default: op = 3'($urandom_range(0, 7));
            endcase
            we   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(128, 160))
                                                : 32'($urandom_range(0, 127));
            do_txn(p, addr, we, op, $urandom(), int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 32; i++) check("final_mem", mem[i], ref_mem[i]);
        check("strobe_overlap", 32'(overlap_cnt), 32'd0);
        check("strobe_addr_op", 32'(badaddr_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
